sprite_compositor: RTL and testbench

- Consumes the per-sprite RGB streams produced by the sprite generators (block, circle, triangle, line) and merges them into a single pixel stream for the video output stage.
- Fixed layer priority, per-frame shadowed layer enables and background colour, frame-rate blink control, and a per-frame sprite-collision flag.
- Pipelined; delays hsync/vsync/active_draw to match the pixel latency.

---
 rtl/video_pkg.sv | 25 ++
 rtl/layer_priority_encoder.sv | 22 ++
 rtl/sprite_compositor.sv | 202 ++++++++++++++++++++
 tb/tb_sprite_compositor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions for the sprite pipeline: pixel colour type,
// compositor latency and the 1280x720 timing constants used by the generators.
package video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int COMPOSITOR_LATENCY = 2;

    localparam int H_ACTIVE = 1280;
    localparam int H_FRONT  = 110;
    localparam int H_SYNC   = 40;
    localparam int H_BACK   = 220;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 720;
    localparam int V_FRONT  = 5;
    localparam int V_SYNC   = 5;
    localparam int V_BACK   = 20;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/layer_priority_encoder.sv
// Picks the lowest-index set bit of the opaque vector; index is N when
// nothing is opaque so it doubles as the background code.
module layer_priority_encoder #(
    parameter int N  = 4,
    parameter int LW = $clog2(N) + 1
) (
    input  logic [N-1:0]  i_opaque,
    output logic          o_valid,
    output logic [LW-1:0] o_index
);

    always_comb begin
        o_valid = |i_opaque;
        o_index = LW'(N);
        for (int i = N - 1; i >= 0; i--) begin
            if (i_opaque[i]) begin
                o_index = LW'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: priority-merges sprite layers over a per-frame
// background, with frame-rate blinking and a per-frame collision flag.
module sprite_compositor
    import video_pkg::*;
#(
    parameter  int NUM_LAYERS   = 4,
    parameter  int BLINK_FRAMES = 30,
    localparam int LW           = $clog2(NUM_LAYERS) + 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [10:0]             hcount_in,
    input  logic [9:0]              vcount_in,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    active_draw_in,
    input  logic                    new_frame_in,
    input  logic [24*NUM_LAYERS-1:0] layer_rgb_in,
    input  logic [NUM_LAYERS-1:0]   layer_en_in,
    input  logic [NUM_LAYERS-1:0]   blink_mask_in,
    input  logic [23:0]             bg_color_in,
    output logic [7:0]              red_out,
    output logic [7:0]              green_out,
    output logic [7:0]              blue_out,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    active_draw_out,
    output logic [10:0]             hcount_out,
    output logic [9:0]              vcount_out,
    output logic [LW-1:0]           hit_layer_out,
    output logic                    collision_out
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NUM_LAYERS-1:0]    r_en_q;
    logic [NUM_LAYERS-1:0]    r_blink_mask_q;
    rgb_t                     r_bg_q;
    logic [CW-1:0]            r_blink_cnt;
    logic                     r_blink_phase;
    logic [NUM_LAYERS-1:0]    w_eff_en;
    logic [NUM_LAYERS-1:0]    w_opaque;

    logic                     r1_valid;
    logic [24*NUM_LAYERS-1:0] r1_layers;
    logic [NUM_LAYERS-1:0]    r1_opaque;
    rgb_t                     r1_bg;
    logic [10:0]              r1_hcount;
    logic [9:0]               r1_vcount;
    logic                     r1_hsync;
    logic                     r1_vsync;
    logic                     r1_active;

    logic [LW-1:0]            w_pop;
    logic                     w_overlap;
    logic                     w_hit_valid;
    logic [LW-1:0]            w_hit_idx;
    rgb_t                     w_sel_rgb;
    logic [LW-1:0]            w_sel_hit;

    rgb_t                     r2_rgb;
    logic [LW-1:0]            r2_hit;
    logic [10:0]              r2_hcount;
    logic [9:0]               r2_vcount;
    logic                     r2_hsync;
    logic                     r2_vsync;
    logic                     r2_active;
    logic                     r_coll_acc;
    logic                     r_collision;

    // Frame-boundary shadows and blink counter all move on the same new_frame edge
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_en_q         <= '0;
            r_blink_mask_q <= '0;
            r_bg_q         <= '0;
            r_blink_cnt    <= '0;
            r_blink_phase  <= 1'b0;
        end else if (new_frame_in) begin
            r_en_q         <= layer_en_in;
            r_blink_mask_q <= blink_mask_in;
            r_bg_q         <= rgb_t'(bg_color_in);
            if (r_blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + CW'(1);
            end
        end
    end

    assign w_eff_en = r_en_q & ~(r_blink_mask_q & {NUM_LAYERS{r_blink_phase}});

    always_comb begin
        w_opaque = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_opaque[i] = w_eff_en[i] && (layer_rgb_in[24*i +: 24] != 24'd0);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r1_valid  <= 1'b0;
            r1_layers <= '0;
            r1_opaque <= '0;
            r1_bg     <= '0;
            r1_hcount <= '0;
            r1_vcount <= '0;
            r1_hsync  <= 1'b0;
            r1_vsync  <= 1'b0;
            r1_active <= 1'b0;
        end else begin
            r1_valid  <= 1'b1;
            r1_layers <= layer_rgb_in;
            r1_opaque <= w_opaque;
            r1_bg     <= r_bg_q;
            r1_hcount <= hcount_in;
            r1_vcount <= vcount_in;
            r1_hsync  <= hsync_in;
            r1_vsync  <= vsync_in;
            r1_active <= active_draw_in;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_pop = w_pop + LW'(r1_opaque[i]);
        end
    end

    assign w_overlap = r1_valid && r1_active && ({1'b0, w_pop} >= (LW+1)'(2));

    layer_priority_encoder #(
        .N  (NUM_LAYERS),
        .LW (LW)
    ) u_prio (
        .i_opaque (r1_opaque),
        .o_valid  (w_hit_valid),
        .o_index  (w_hit_idx)
    );

    always_comb begin
        w_sel_rgb = r1_bg;
        w_sel_hit = LW'(NUM_LAYERS);
        if (!(r1_valid && r1_active)) begin
            w_sel_rgb = '0;
        end else if (w_hit_valid) begin
            w_sel_hit = w_hit_idx;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (w_hit_idx == LW'(i)) begin
                    w_sel_rgb = rgb_t'(r1_layers[24*i +: 24]);
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r2_rgb    <= '0;
            r2_hit    <= LW'(NUM_LAYERS);
            r2_hcount <= '0;
            r2_vcount <= '0;
            r2_hsync  <= 1'b0;
            r2_vsync  <= 1'b0;
            r2_active <= 1'b0;
        end else begin
            r2_rgb    <= w_sel_rgb;
            r2_hit    <= w_sel_hit;
            r2_hcount <= r1_hcount;
            r2_vcount <= r1_vcount;
            r2_hsync  <= r1_hsync;
            r2_vsync  <= r1_vsync;
            r2_active <= r1_active;
        end
    end

    // An overlap sitting in stage 1 on the frame edge is folded straight into the flag
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_coll_acc  <= 1'b0;
            r_collision <= 1'b0;
        end else if (new_frame_in) begin
            r_collision <= r_coll_acc | w_overlap;
            r_coll_acc  <= 1'b0;
        end else if (w_overlap) begin
            r_coll_acc <= 1'b1;
        end
    end

    assign red_out         = r2_rgb.r;
    assign green_out       = r2_rgb.g;
    assign blue_out        = r2_rgb.b;
    assign hit_layer_out   = r2_hit;
    assign hcount_out      = r2_hcount;
    assign vcount_out      = r2_vcount;
    assign hsync_out       = r2_hsync;
    assign vsync_out       = r2_vsync;
    assign active_draw_out = r2_active;
    assign collision_out   = r_collision;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: expected pixels are queued at issue
// time and a negedge monitor retires them when the pipeline presents them.
module tb_sprite_compositor;
    import video_pkg::*;

    logic        clock = 1'b0;
    logic        resetN;
    logic [10:0] hCount;
    logic [9:0]  vCount;
    logic        hSync;
    logic        vSync;
    logic        activeDraw;
    logic        newFrame;
    logic [95:0] layerRgb;
    logic [3:0]  layerEn;
    logic [3:0]  blinkMask;
    logic [23:0] bgColor;

    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hSyncOut;
    logic        vSyncOut;
    logic        activeOut;
    logic [10:0] hCountOut;
    logic [9:0]  vCountOut;
    logic [2:0]  hitLayer;
    logic        collision;

    typedef struct {
        int          cyc;
        logic [23:0] rgb;
        logic [2:0]  hit;
        logic        hs;
        logic        vs;
        logic        act;
        logic [10:0] hc;
        logic [9:0]  vc;
    } expect_t;

    expect_t scoreboard[$];
    int cycle        = 0;
    int nVectors     = 0;
    int nMiscompares = 0;

    sprite_compositor #(
        .NUM_LAYERS   (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk_in          (clock),
        .rst_in          (resetN),
        .hcount_in       (hCount),
        .vcount_in       (vCount),
        .hsync_in        (hSync),
        .vsync_in        (vSync),
        .active_draw_in  (activeDraw),
        .new_frame_in    (newFrame),
        .layer_rgb_in    (layerRgb),
        .layer_en_in     (layerEn),
        .blink_mask_in   (blinkMask),
        .bg_color_in     (bgColor),
        .red_out         (red),
        .green_out       (green),
        .blue_out        (blue),
        .hsync_out       (hSyncOut),
        .vsync_out       (vSyncOut),
        .active_draw_out (activeOut),
        .hcount_out      (hCountOut),
        .vcount_out      (vCountOut),
        .hit_layer_out   (hitLayer),
        .collision_out   (collision)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Stop a runaway simulation with a visible failure
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [95:0] pack(input logic [23:0] l3, input logic [23:0] l2,
                                         input logic [23:0] l1, input logic [23:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    // Drive one pixel just after a rising edge and queue its hand-computed result
    task automatic applyStimulus(input logic act, input logic nf, input logic [95:0] layers,
                                 input logic [23:0] expRgb, input logic [2:0] expHit);
        expect_t e;
        @(posedge clock);
        #1;
        hCount     = hCount + 11'd1;
        hSync      = hCount[0];
        vSync      = hCount[1];
        vCount     = vCount + {9'd0, nf};
        activeDraw = act;
        newFrame   = nf;
        layerRgb   = layers;
        e.cyc = cycle;
        e.rgb = expRgb;
        e.hit = expHit;
        e.hs  = hSync;
        e.vs  = vSync;
        e.act = act;
        e.hc  = hCount;
        e.vc  = vCount;
        scoreboard.push_back(e);
    endtask

    task automatic drainQueue();
        @(posedge clock);
        #1;
        newFrame   = 1'b0;
        activeDraw = 1'b0;
        layerRgb   = '0;
        for (int i = 0; i < 20 && scoreboard.size() > 0; i++) @(posedge clock);
        if (scoreboard.size() > 0) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
            scoreboard.delete();
        end
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        expect_t e;
        while (scoreboard.size() > 0 && scoreboard[0].cyc + COMPOSITOR_LATENCY < cycle) begin
            e = scoreboard.pop_front();
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL missed pix%0d: seen at cycle %0d, required by %0d", e.cyc, cycle,
                     e.cyc + COMPOSITOR_LATENCY);
        end
        if (scoreboard.size() > 0 && scoreboard[0].cyc + COMPOSITOR_LATENCY == cycle) begin
            e = scoreboard.pop_front();
            checkOutput($sformatf("pix%0d", e.cyc),
                        {13'd0, red, green, blue, hitLayer, hSyncOut, vSyncOut, activeOut, hCountOut, vCountOut},
                        {13'd0, e.rgb, e.hit, e.hs, e.vs, e.act, e.hc, e.vc});
        end
    end

    initial begin
        resetN     = 1'b0;
        hCount     = '0;
        vCount     = '0;
        hSync      = 1'b0;
        vSync      = 1'b0;
        activeDraw = 1'b0;
        newFrame   = 1'b0;
        layerRgb   = '0;
        layerEn    = '0;
        blinkMask  = '0;
        bgColor    = '0;

        repeat (3) @(negedge clock);
        checkOutput("rst_rgb", {red, green, blue}, 24'h0);
        checkOutput("rst_hit", hitLayer, 3'd4);
        checkOutput("rst_coll", collision, 1'b0);
        checkOutput("rst_ctrl", {hSyncOut, vSyncOut, activeOut, hCountOut, vCountOut}, 24'h0);
        @(posedge clock);
        #1;
        resetN = 1'b1;

        // Nothing enabled yet and background is black
        applyStimulus(1, 0, '0, 24'h0, 3'd4);
        applyStimulus(1, 0, pack(0, 0, 0, 24'hAA5500), 24'h0, 3'd4);

        layerEn   = 4'b1111;
        bgColor   = 24'h102030;
        blinkMask = 4'b0000;
        applyStimulus(0, 1, '0, 24'h0, 3'd4);
        applyStimulus(1, 0, '0, 24'h102030, 3'd4);
        applyStimulus(1, 0, pack(24'h0000FF, 0, 0, 0), 24'h0000FF, 3'd3);
        applyStimulus(0, 0, pack(24'hFFFFFF, 0, 0, 24'h111111), 24'h0, 3'd4);

        // Overlapping layers: priority and collision accumulation
        applyStimulus(1, 0, pack(0, 24'h00FF00, 24'hFF0000, 0), 24'hFF0000, 3'd1);
        applyStimulus(1, 0, pack(0, 24'hABCDEF, 0, 24'h123456), 24'h123456, 3'd0);
        drainQueue();
        checkOutput("coll_before", collision, 1'b0);
        applyStimulus(0, 1, '0, 24'h0, 3'd4);
        applyStimulus(1, 0, pack(0, 24'h00FF00, 0, 0), 24'h00FF00, 3'd2);
        drainQueue();
        checkOutput("coll_set", collision, 1'b1);
        applyStimulus(0, 1, '0, 24'h0, 3'd4);
        applyStimulus(1, 0, pack(0, 24'h00FF00, 0, 0), 24'h00FF00, 3'd2);
        drainQueue();
        checkOutput("coll_clear", collision, 1'b0);

        // Overlap in flight exactly at the frame pulse
        applyStimulus(1, 0, pack(0, 0, 24'h020202, 24'h010101), 24'h010101, 3'd0);
        applyStimulus(0, 1, '0, 24'h0, 3'd4);
        drainQueue();
        checkOutput("coll_boundary", collision, 1'b1);
        applyStimulus(0, 1, '0, 24'h0, 3'd4);
        drainQueue();
        checkOutput("coll_clear2", collision, 1'b0);

        // Enable change is shadowed until the frame pulse
        layerEn = 4'b1101;
        applyStimulus(1, 0, pack(0, 0, 24'hFF0000, 0), 24'hFF0000, 3'd1);
        applyStimulus(1, 1, pack(0, 0, 24'hFF0000, 0), 24'hFF0000, 3'd1);
        applyStimulus(1, 0, pack(0, 0, 24'hFF0000, 0), 24'h102030, 3'd4);

        // Blink on layer 0 with a two-frame half period
        layerEn   = 4'b1111;
        blinkMask = 4'b0001;
        applyStimulus(0, 1, '0, 24'h0, 3'd4);
        applyStimulus(1, 0, pack(0, 0, 0, 24'hAA5500), 24'h102030, 3'd4);
        applyStimulus(0, 1, '0, 24'h0, 3'd4);
        applyStimulus(1, 0, pack(0, 0, 0, 24'hAA5500), 24'hAA5500, 3'd0);
        applyStimulus(0, 1, '0, 24'h0, 3'd4);
        applyStimulus(1, 0, pack(0, 0, 0, 24'hAA5500), 24'hAA5500, 3'd0);
        bgColor = 24'h405060;
        applyStimulus(0, 1, '0, 24'h0, 3'd4);
        applyStimulus(1, 0, pack(0, 0, 0, 24'hAA5500), 24'h405060, 3'd4);
        applyStimulus(0, 1, '0, 24'h0, 3'd4);
        applyStimulus(1, 0, pack(0, 0, 0, 24'hAA5500), 24'h405060, 3'd4);
        applyStimulus(0, 1, '0, 24'h0, 3'd4);
        applyStimulus(1, 0, pack(0, 0, 0, 24'hAA5500), 24'hAA5500, 3'd0);
        drainQueue();

        // Asynchronous reset in the middle of a visible line
        activeDraw = 1'b1;
        layerRgb   = pack(0, 0, 0, 24'hAA5500);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("prerst_rgb", {red, green, blue, hitLayer}, {24'hAA5500, 3'd0});
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("arst_rgb", {red, green, blue}, 24'h0);
        checkOutput("arst_hit", hitLayer, 3'd4);
        checkOutput("arst_ctrl", {hSyncOut, vSyncOut, activeOut, hCountOut, vCountOut}, 24'h0);
        @(posedge clock);
        #1;
        resetN = 1'b1;

        applyStimulus(1, 0, pack(0, 0, 0, 24'hAA5500), 24'h0, 3'd4);
        layerEn   = 4'b1111;
        blinkMask = 4'b0000;
        bgColor   = 24'h102030;
        applyStimulus(1, 1, pack(0, 0, 0, 24'hAA5500), 24'h0, 3'd4);
        applyStimulus(1, 0, pack(0, 0, 0, 24'hAA5500), 24'hAA5500, 3'd0);
        applyStimulus(1, 0, '0, 24'h102030, 3'd4);
        drainQueue();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
